// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU operation codes, FSM states, requester id.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational XLEN-bit ALU; results wrap modulo 2^XLEN, unknown op codes return operand a.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEL_W = 4
) (
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [SEL_W-1:0] i_sel,
    output logic [XLEN-1:0]  o_result
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    logic           w_lt_s;
    logic           w_lt_u;

    assign w_shamt = i_b[SHW-1:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    always_comb begin
        o_result = i_a;
        case (i_sel)
            SEL_W'(ALU_ADD):  o_result = i_a + i_b;
            SEL_W'(ALU_SUB):  o_result = i_a - i_b;
            SEL_W'(ALU_AND):  o_result = i_a & i_b;
            SEL_W'(ALU_OR):   o_result = i_a | i_b;
            SEL_W'(ALU_XOR):  o_result = i_a ^ i_b;
            SEL_W'(ALU_SLL):  o_result = i_a << w_shamt;
            SEL_W'(ALU_SRL):  o_result = i_a >> w_shamt;
            SEL_W'(ALU_SRA):  o_result = $signed(i_a) >>> w_shamt;
            SEL_W'(ALU_SLT):  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
            SEL_W'(ALU_SLTU): o_result = {{(XLEN-1){1'b0}}, w_lt_u};
            default:          o_result = i_a;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU with a one-entry registered result slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [XLEN-1:0]  req_a_0,
    input  logic [XLEN-1:0]  req_b_0,
    input  logic [SEL_W-1:0] req_sel_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [XLEN-1:0]  req_a_1,
    input  logic [XLEN-1:0]  req_b_1,
    input  logic [SEL_W-1:0] req_sel_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output req_id_t          rsp_id,
    output logic [XLEN-1:0]  rsp_result
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [XLEN-1:0]  r_result;
    req_id_t          r_id;

    logic             w_slot_free;
    logic             w_win1;
    logic             w_accept;
    req_id_t          w_sel_id;
    logic [XLEN-1:0]  w_alu_a;
    logic [XLEN-1:0]  w_alu_b;
    logic [SEL_W-1:0] w_alu_sel;
    logic [XLEN-1:0]  w_alu_result;

`ifdef ALU_ARB_RR_EN
    // Requester favoured on the next contested grant.
    req_id_t          r_prio;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_sel_id;
        end
    end

    assign w_win1 = req_valid_1 && (!req_valid_0 || r_prio);
`else
    assign w_win1 = req_valid_1 && !req_valid_0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_slot_free = (r_state == ST_EMPTY) || rsp_ready;
        req_ready_1 = w_slot_free && w_win1;
        req_ready_0 = w_slot_free && req_valid_0 && !w_win1;
        w_accept    = req_ready_0 || req_ready_1;
        w_sel_id    = req_ready_1;
        rsp_valid   = (r_state == ST_FULL);
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (r_state == ST_FULL && rsp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    assign w_alu_a   = w_sel_id ? req_a_1   : req_a_0;
    assign w_alu_b   = w_sel_id ? req_b_1   : req_b_0;
    assign w_alu_sel = w_sel_id ? req_sel_1 : req_sel_0;

    alu_arbiter_alu #(
        .XLEN  (XLEN),
        .SEL_W (SEL_W)
    ) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_sel    (w_alu_sel),
        .o_result (w_alu_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_id     <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_alu_result;
            r_id     <= w_sel_id;
        end
    end

    assign rsp_result = r_result;
    assign rsp_id     = r_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter; honours ALU_ARB_RR_EN when defined for the build.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_0, req_ready_0, req_valid_1, req_ready_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0]  req_sel_0, req_sel_1;
    logic        rsp_valid, rsp_ready;
    req_id_t     rsp_id;
    logic [31:0] rsp_result;

    alu_arbiter #(.XLEN(32), .SEL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sel_0(req_sel_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sel_1(req_sel_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   m_full = 1'b0;
`ifdef ALU_ARB_RR_EN
    bit   m_prio = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (sel)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + (~b) + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ALU_SLT:  return ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return a;
        endcase
    endfunction

    // Called at the falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit   g0, g1, slot;
        exp_t e;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        slot = !m_full || rsp_ready;
        if (slot) begin
            if (req_valid_0 && req_valid_1) begin
`ifdef ALU_ARB_RR_EN
                g1 = m_prio;
                g0 = !m_prio;
`else
                g0 = 1'b1;
`endif
            end else begin
                g0 = req_valid_0;
                g1 = req_valid_1;
            end
        end
        check("req_ready_0", 64'(req_ready_0), 64'(g0));
        check("req_ready_1", 64'(req_ready_1), 64'(g1));
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            check("sb_depth", 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        if (g0 || g1) begin
            e.id  = g1;
            e.res = g1 ? alu_model(req_sel_1, req_a_1, req_b_1) : alu_model(req_sel_0, req_a_0, req_b_0);
            sb.push_back(e);
`ifdef ALU_ARB_RR_EN
            m_prio = !g1;
`endif
        end
        m_full = (g0 || g1) || (m_full && !rsp_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_sel_0 = s;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_sel_1 = s;
    endtask

    initial begin
        logic exp_id;
        reset = 1'b1;
        rsp_ready = 1'b0;
        set_req0(1'b0, '0, '0, '0);
        set_req1(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 3 + 4 on requester 0
        rsp_ready = 1'b1;
        set_req0(1'b1, 32'd3, 32'd4, ALU_ADD);
        step();
        set_req0(1'b0, '0, '0, '0);
        #1;
        check("add_valid", 64'(rsp_valid), 64'd1);
        check("add_result", 64'(rsp_result), 64'd7);
        check("add_id", 64'(rsp_id), 64'd0);
        step();

        // wraparound and undefined op code
        set_req1(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
        step();
        set_req1(1'b0, '0, '0, '0);
        #1;
        check("wrap_result", 64'(rsp_result), 64'd0);
        set_req0(1'b1, 32'h0000_1234, 32'h55, 4'hC);
        step();
        set_req0(1'b0, '0, '0, '0);
        #1;
        check("undef_result", 64'(rsp_result), 64'h1234);
        step();

        // backpressure: hold for 3 cycles while requesters keep changing
        set_req0(1'b1, 32'd100, 32'd1, ALU_SUB);
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req0(1'b1, $urandom, $urandom, 4'($urandom_range(0, 11)));
            set_req1(1'b1, $urandom, $urandom, 4'($urandom_range(0, 11)));
            step();
            check("hold_result", 64'(rsp_result), 64'd99);
        end
        rsp_ready = 1'b1;
        step();
        set_req0(1'b0, '0, '0, '0);
        set_req1(1'b0, '0, '0, '0);
        step();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_req0(1'($urandom_range(0, 1)), (i % 17 == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                     4'($urandom_range(0, 11)));
            set_req1(1'($urandom_range(0, 1)), (i % 13 == 0) ? 32'h8000_0000 : $urandom, $urandom,
                     4'($urandom_range(0, 11)));
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // reset while a result is held
        rsp_ready = 1'b0;
        set_req0(1'b1, 32'd5, 32'd6, ALU_XOR);
        set_req1(1'b0, '0, '0, '0);
        step();
        set_req0(1'b0, '0, '0, '0);
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_id", 64'(rsp_id), 64'd0);
        check("arst_result", 64'(rsp_result), 64'd0);
        sb.delete();
        m_full = 1'b0;
`ifdef ALU_ARB_RR_EN
        m_prio = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // both requesters valid continuously after reset
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, $urandom, $urandom, 4'($urandom_range(0, 9)));
            set_req1(1'b1, $urandom, $urandom, 4'($urandom_range(0, 9)));
            step();
`ifdef ALU_ARB_RR_EN
            exp_id = 1'(i % 2);
`else
            exp_id = 1'b0;
`endif
            #1;
            check("seq_id", 64'(rsp_id), 64'(exp_id));
        end
        set_req0(1'b0, '0, '0, '0);
        set_req1(1'b0, '0, '0, '0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits.
REQ-002 Parameter SEL_W, default 4, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid_0  input  1  requester 0 has an operation pending.
REQ-006 req_ready_0  output  1  requester 0 operation accepted this cycle when high with req_valid_0.
REQ-007 req_a_0, req_b_0  input  XLEN  requester 0 operands.
REQ-008 req_sel_0  input  SEL_W  requester 0 ALU operation code.
REQ-009 req_valid_1, req_ready_1, req_a_1, req_b_1, req_sel_1  same directions/widths as requester 0, for requester 1.
REQ-010 rsp_valid  output  1  registered result available.
REQ-011 rsp_ready  input  1  consumer takes result this cycle when high with rsp_valid.
REQ-012 rsp_id  output  1  requester that issued the current result.
REQ-013 rsp_result  output  XLEN  registered ALU result.

Function
REQ-014 Block SHALL be a two-state FSM: EMPTY (no result held) and FULL (result held in output register).
REQ-015 Output slot free = state EMPTY, or state FULL with rsp_ready high.
REQ-016 When slot free, arbiter SHALL grant exactly one requester with req_valid high; req_ready of the granted requester SHALL be high, the other low; combinational from req_valid, rsp_ready, state, priority.
REQ-017 When slot not free, both req_ready SHALL be low.
REQ-018 On accept, selected a/b/sel SHALL drive the ALU; result and id SHALL be registered; rsp_valid SHALL be high on the next cycle (latency 1).
REQ-019 Accept and drain in the same cycle SHALL be legal: state stays FULL, new result replaces old; sustained throughput one operation per cycle.
REQ-020 Drain with no accept SHALL move FULL to EMPTY; rsp_valid low next cycle.
REQ-021 While rsp_valid high and rsp_ready low, rsp_result and rsp_id SHALL hold stable.
REQ-022 Arithmetic SHALL be exactly the ALU's: XLEN-bit, modulo 2^XLEN, no carry/overflow output; undefined sel codes pass through unchanged.
REQ-023 Requester inputs are sampled only on the accept cycle; changes at other times SHALL have no effect.

Reset
REQ-024 Asserting reset SHALL immediately force state EMPTY, rsp_valid 0, rsp_id 0, rsp_result 0, priority pointer to requester 0, regardless of operation in progress.
REQ-025 Accepted-but-undrained result at reset SHALL be discarded; no response re-issued.
REQ-026 First grant after reset release SHALL favour requester 0 when both valid.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; on a contested grant, requester not granted last SHALL win; pointer updates on every accept.
REQ-028 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-029 ALU operation codes (existing ALU select constants), FSM state enum, and requester-id typedef SHALL live in the shared types package.
REQ-030 Exactly one sub-module: existing ALU, instanced combinationally between the request mux and the output register.

Verification
REQ-031 req_valid_0=1, a=3, b=4, sel=ADD, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=7, rsp_id=0.
REQ-032 Both valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0,0 without.
REQ-033 FULL, rsp_ready=0 for 3 cycles -> rsp_result/rsp_id unchanged, req_ready_0=req_ready_1=0; rsp_ready=1 -> new grant same cycle.
REQ-034 a=0xFFFFFFFF, b=1, sel=ADD -> rsp_result=0x00000000.
REQ-035 reset asserted while rsp_valid=1 -> rsp_valid=0 before next clock edge; after release both valid -> first rsp_id=0.
